// File: rtl/block_field.sv
// Brick wall: ROWS x COLS presence bitmap, 1-clock brick layer renderer, hit query
// handshake and row-sweep reload. Optional feature macro: BLOCK_FIELD_HIT_FLASH_EN.
module block_field #(
  parameter int COLS       = 8,
  parameter int ROWS       = 4,
  parameter int BLK_W_LOG2 = 6,
  parameter int BLK_H_LOG2 = 4,
  parameter int ORG_X      = 64,
  parameter int ORG_Y      = 48,
  parameter int FLASH_LEN  = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       init,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic       visible,
  output logic [3:0] oBlock,
  input  logic       hit_req,
  input  logic [9:0] hit_x,
  input  logic [9:0] hit_y,
  output logic       hit_ack,
  output logic       hit_hit,
  output logic [5:0] remaining,
  output logic       cleared,
  output logic       busy
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [9:0] X_MASK = 10'((1 << BLK_W_LOG2) - 1);
  localparam logic [9:0] Y_MASK = 10'((1 << BLK_H_LOG2) - 1);

  typedef enum logic {IDLE, LOAD} state_e;

  state_e                      state_q, state_d;
  logic [ROWS-1:0][COLS-1:0]   bitmap_q, bitmap_d;
  logic [5:0]                  rem_q, rem_d;
  logic [RW-1:0]               k_q, k_d;
  logic                        ack_q, ack_d, hit_q, hit_d;
  logic [3:0]                  oblock_q, oblock_d;

  // Hit address decode; compares precede subtraction so no wrap-around hits.
  logic [9:0] h_dx, h_dy, h_col, h_row;
  logic       h_in;
  always_comb begin
    h_dx  = hit_x - 10'(ORG_X);
    h_dy  = hit_y - 10'(ORG_Y);
    h_col = h_dx >> BLK_W_LOG2;
    h_row = h_dy >> BLK_H_LOG2;
    h_in  = (hit_x >= 10'(ORG_X)) && (hit_y >= 10'(ORG_Y)) &&
            (h_col < 10'(COLS)) && (h_row < 10'(ROWS));
  end

  always_comb begin
    state_d  = state_q;
    bitmap_d = bitmap_q;
    rem_d    = rem_q;
    k_d      = k_q;
    ack_d    = 1'b0;
    hit_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (init) begin
          bitmap_d = '0;
          rem_d    = '0;
          k_d      = '0;
          state_d  = LOAD;
        end else if (hit_req && !ack_q) begin
          ack_d = 1'b1;
          if (h_in && bitmap_q[h_row[RW-1:0]][h_col[CW-1:0]]) begin
            hit_d = 1'b1;
            bitmap_d[h_row[RW-1:0]][h_col[CW-1:0]] = 1'b0;
            if (rem_q != '0) rem_d = rem_q - 6'd1;
          end
        end
      end
      LOAD: begin
        if (init) begin
          bitmap_d = '0;
          rem_d    = '0;
          k_d      = '0;
        end else begin
          bitmap_d[k_q] = '1;
          rem_d         = rem_q + 6'(COLS);
          if (k_q == RW'(ROWS - 1)) state_d = IDLE;
          else                      k_d     = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BLOCK_FIELD_HIT_FLASH_EN
  localparam int FW = $clog2(FLASH_LEN + 1);
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic [RW-1:0] flash_row_q, flash_row_d;
  logic [CW-1:0] flash_col_q, flash_col_d;

  always_comb begin
    flash_cnt_d = (flash_cnt_q != '0) ? flash_cnt_q - 1'b1 : '0;
    flash_row_d = flash_row_q;
    flash_col_d = flash_col_q;
    if (init) begin
      flash_cnt_d = '0;
    end else if (hit_d) begin
      flash_cnt_d = FW'(FLASH_LEN);
      flash_row_d = h_row[RW-1:0];
      flash_col_d = h_col[CW-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flash_cnt_q <= '0;
      flash_row_q <= '0;
      flash_col_q <= '0;
    end else begin
      flash_cnt_q <= flash_cnt_d;
      flash_row_q <= flash_row_d;
      flash_col_q <= flash_col_d;
    end
  end
`endif

  // Render path: one registered stage from px/py/visible to oBlock.
  logic [9:0] r_dx, r_dy, r_col, r_row;
  logic [2:0] r_rgb;
  logic       r_in, r_gap;
  always_comb begin
    r_dx     = px - 10'(ORG_X);
    r_dy     = py - 10'(ORG_Y);
    r_col    = r_dx >> BLK_W_LOG2;
    r_row    = r_dy >> BLK_H_LOG2;
    r_in     = (px >= 10'(ORG_X)) && (py >= 10'(ORG_Y)) &&
               (r_col < 10'(COLS)) && (r_row < 10'(ROWS));
    r_gap    = ((r_dx & X_MASK) == '0) || ((r_dy & Y_MASK) == '0);
    r_rgb    = 3'(r_row % 10'd7) + 3'd1;
    oblock_d = '0;
    if (visible && r_in && !r_gap && bitmap_q[r_row[RW-1:0]][r_col[CW-1:0]])
      oblock_d = {1'b1, r_rgb};
`ifdef BLOCK_FIELD_HIT_FLASH_EN
    if (visible && r_in && !r_gap && (flash_cnt_q != '0) &&
        (r_row[RW-1:0] == flash_row_q) && (r_col[CW-1:0] == flash_col_q))
      oblock_d = 4'b1111;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      bitmap_q <= '1;
      rem_q    <= 6'(ROWS * COLS);
      k_q      <= '0;
      ack_q    <= 1'b0;
      hit_q    <= 1'b0;
      oblock_q <= '0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
      rem_q    <= rem_d;
      k_q      <= k_d;
      ack_q    <= ack_d;
      hit_q    <= hit_d;
      oblock_q <= oblock_d;
    end
  end

  assign oBlock    = oblock_q;
  assign hit_ack   = ack_q;
  assign hit_hit   = hit_q;
  assign remaining = rem_q;
  assign busy      = (state_q == LOAD);
  assign cleared   = (rem_q == '0) && (state_q != LOAD);
endmodule

// File: tb/tb_block_field.sv
// Directed bench for block_field: render, hit handshake, clear-all, reload, async reset.
module tb_block_field;
  localparam int OX = 64;
  localparam int OY = 48;

  logic       clock = 1'b0;
  logic       reset, init, visible, hit_req;
  logic [9:0] px, py, hit_x, hit_y;
  logic [3:0] oBlock;
  logic       hit_ack, hit_hit, cleared, busy;
  logic [5:0] remaining;

  int n_cmp = 0;
  int n_bad = 0;

  block_field dut (
    .clock(clock), .reset(reset), .init(init), .px(px), .py(py), .visible(visible),
    .oBlock(oBlock), .hit_req(hit_req), .hit_x(hit_x), .hit_y(hit_y),
    .hit_ack(hit_ack), .hit_hit(hit_hit), .remaining(remaining),
    .cleared(cleared), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic render(input int x, input int y, input logic v, input logic [3:0] exp,
                        input string tag);
    px = 10'(x); py = 10'(y); visible = v;
    tick();
    chk(tag, 32'(oBlock), 32'(exp));
  endtask

  task automatic do_hit(input int x, input int y, input logic exp_hit, input int exp_rem,
                        input string tag);
    logic got;
    got = 1'b0;
    hit_x = 10'(x); hit_y = 10'(y); hit_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (hit_ack) got = 1'b1;
    end
    hit_req = 1'b0;
    chk({tag, "_ack"}, 32'(got), 32'd1);
    chk({tag, "_hit"}, 32'(hit_hit), 32'(exp_hit));
    chk({tag, "_rem"}, 32'(remaining), 32'(exp_rem));
    tick();
    chk({tag, "_ack_once"}, 32'(hit_ack), 32'd0);
  endtask

  initial begin
    int exp_rem;
    logic exp_hit;
    reset = 1'b0; init = 1'b0; visible = 1'b0; hit_req = 1'b0;
    px = '0; py = '0; hit_x = '0; hit_y = '0;
    #12;
    chk("rst_oblock", 32'(oBlock), 32'd0);
    chk("rst_rem", 32'(remaining), 32'd32);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cleared", 32'(cleared), 32'd0);
    chk("rst_ack", 32'(hit_ack), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    render(OX + 1, OY + 1, 1'b1, 4'b1001, "first_pixel");
    chk("rem_after_rst", 32'(remaining), 32'd32);
    chk("cleared_after_rst", 32'(cleared), 32'd0);
    render(OX + 64, OY + 1, 1'b1, 4'b0000, "gap_col");
    render(OX + 1, OY + 16, 1'b1, 4'b0000, "gap_row");
    render(OX + 8 * 64, OY + 1, 1'b1, 4'b0000, "right_edge");
    render(OX - 1, OY + 1, 1'b1, 4'b0000, "left_out");
    render(OX + 1, OY + 4 * 16 + 1, 1'b1, 4'b0000, "below_field");
    render(OX + 1, OY + 1, 1'b0, 4'b0000, "not_visible");
    render(OX + 65, OY + 17, 1'b1, 4'b1010, "row1_col1");
    render(OX + 7 * 64 + 63, OY + 3 * 16 + 15, 1'b1, 4'b1100, "row3_col7");

    do_hit(OX + 70, OY + 20, 1'b1, 31, "hit11");
    render(OX + 65, OY + 17, 1'b1, 4'b0000, "row1_col1_gone");
    do_hit(OX + 70, OY + 20, 1'b0, 31, "rehit11");

    do_hit(OX + 3 * 64 + 10, OY + 2 * 16 + 5, 1'b1, 30, "hit23");
`ifdef BLOCK_FIELD_HIT_FLASH_EN
    render(OX + 3 * 64 + 10, OY + 2 * 16 + 5, 1'b1, 4'b1111, "flash_on");
    render(OX + 3 * 64, OY + 2 * 16 + 5, 1'b1, 4'b0000, "flash_gap");
    repeat (1100) tick();
    render(OX + 3 * 64 + 10, OY + 2 * 16 + 5, 1'b1, 4'b0000, "flash_off");
`else
    render(OX + 3 * 64 + 10, OY + 2 * 16 + 5, 1'b1, 4'b0000, "row2_col3_gone");
`endif

    exp_rem = 30;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        exp_hit = !((r == 1 && c == 1) || (r == 2 && c == 3));
        if (exp_hit) exp_rem--;
        do_hit(OX + c * 64 + 5, OY + r * 16 + 5, exp_hit, exp_rem, $sformatf("clr_r%0dc%0d", r, c));
      end
    end
    chk("all_clear_rem", 32'(remaining), 32'd0);
    chk("all_clear_flag", 32'(cleared), 32'd1);
    do_hit(OX + 5, OY + 5, 1'b0, 0, "empty_hit");
    do_hit(10, 10, 1'b0, 0, "outside_hit");
    do_hit(OX + 8 * 64 + 1, OY + 5, 1'b0, 0, "col8_hit");

    // init together with a pending request: request waits until the sweep ends
    init = 1'b1; hit_req = 1'b1; hit_x = 10'(OX + 5); hit_y = 10'(OY + 5);
    tick();
    init = 1'b0;
    chk("load0_busy", 32'(busy), 32'd1);
    chk("load0_rem", 32'(remaining), 32'd0);
    chk("load0_ack", 32'(hit_ack), 32'd0);
    chk("load0_cleared", 32'(cleared), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("load%0d_busy", i), 32'(busy), 32'd1);
      chk($sformatf("load%0d_rem", i), 32'(remaining), 32'(8 * i));
      chk($sformatf("load%0d_ack", i), 32'(hit_ack), 32'd0);
    end
    tick();
    chk("load_done_busy", 32'(busy), 32'd0);
    chk("load_done_rem", 32'(remaining), 32'd32);
    chk("load_done_ack", 32'(hit_ack), 32'd0);
    tick();
    chk("post_load_ack", 32'(hit_ack), 32'd1);
    chk("post_load_hit", 32'(hit_hit), 32'd1);
    chk("post_load_rem", 32'(remaining), 32'd31);
    hit_req = 1'b0;
    tick();
    chk("post_load_ack_once", 32'(hit_ack), 32'd0);

    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    chk("pre_restart_rem", 32'(remaining), 32'd8);
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("restart_rem", 32'(remaining), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("rl%0d_rem", i), 32'(remaining), 32'(8 * i));
      chk($sformatf("rl%0d_busy", i), 32'(busy), 32'd1);
    end
    tick();
    chk("rl_done_rem", 32'(remaining), 32'd32);
    chk("rl_done_busy", 32'(busy), 32'd0);
    render(OX + 5, OY + 5, 1'b1, 4'b1001, "reloaded_00");

    // async reset mid-LOAD
    init = 1'b1;
    tick();
    init = 1'b0;
    hit_req = 1'b1; hit_x = 10'(OX + 70); hit_y = 10'(OY + 20);
    px = 10'(OX + 5); py = 10'(OY + 5); visible = 1'b1;
    tick();
    tick();
    chk("midload_oblock", 32'(oBlock), 32'b1001);
    chk("midload_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_load_oblock", 32'(oBlock), 32'd0);
    chk("arst_load_busy", 32'(busy), 32'd0);
    chk("arst_load_rem", 32'(remaining), 32'd32);
    chk("arst_load_cleared", 32'(cleared), 32'd0);
    chk("arst_load_ack", 32'(hit_ack), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // async reset mid-handshake (hit_req still high from above)
    tick();
    chk("hs_ack", 32'(hit_ack), 32'd1);
    chk("hs_hit", 32'(hit_hit), 32'd1);
    chk("hs_rem", 32'(remaining), 32'd31);
    #2 reset = 1'b0;
    #1;
    hit_req = 1'b0;
    chk("arst_hs_ack", 32'(hit_ack), 32'd0);
    chk("arst_hs_hit", 32'(hit_hit), 32'd0);
    chk("arst_hs_rem", 32'(remaining), 32'd32);
    chk("arst_hs_oblock", 32'(oBlock), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    render(OX + 65, OY + 17, 1'b1, 4'b1010, "bitmap_full");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/block_field.md
Name: block_field

Overview:
- Owns the brick wall: stores a ROWS x COLS presence bitmap.
- Renders the per-pixel brick layer word {en, rgb[2:0]} consumed by the frame compositor as its in_block input.
- Serves brick-hit queries from the ball logic through a req/ack handshake.
- Reloads the full wall on an init pulse using a row-sweep state machine, and reports remaining/cleared status to the game controller.

Parameters:
- COLS, 8, bricks per row
- ROWS, 4, brick rows
- BLK_W_LOG2, 6, brick width = 2^6 = 64 px
- BLK_H_LOG2, 4, brick height = 2^4 = 16 px
- ORG_X, 64, field left edge in pixels
- ORG_Y, 48, field top edge in pixels
- FLASH_LEN, 1024, flash duration in clocks (used only with the optional feature)

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- init  in  1  one-cycle pulse: reload the full wall
- px  in  10  current pixel x
- py  in  10  current pixel y
- visible  in  1  active video region
- oBlock  out  4  {en, rgb[2:0]} brick layer for the current pixel, registered
- hit_req  in  1  ball-contact query; held high until hit_ack
- hit_x  in  10  contact x, stable while hit_req is high
- hit_y  in  10  contact y, stable while hit_req is high
- hit_ack  out  1  one-cycle acknowledge
- hit_hit  out  1  valid with hit_ack: 1 = a brick was present and is now cleared
- remaining  out  6  bricks still present
- cleared  out  1  remaining==0 and not busy
- busy  out  1  high while in LOAD

Behaviour:
- Reset (reset low, asynchronous):
  - bitmap all 1s; remaining=ROWS*COLS; state IDLE.
  - oBlock=0, hit_ack=0, hit_hit=0, busy=0, cleared=0.
- Address decode:
  - col = (x-ORG_X)>>BLK_W_LOG2; row = (y-ORG_Y)>>BLK_H_LOG2.
  - Inside the field iff x>=ORG_X, y>=ORG_Y, col<COLS, row<ROWS. Use unsigned compares before subtracting; no wrap-around hits.
- Render pipeline, latency exactly 1 clock from px/py/visible to oBlock:
  - en=1 only if visible, inside the field, the brick bit is set, and the pixel is not a gap pixel.
  - Gap pixels are those where the in-brick x offset==0 or the in-brick y offset==0 (1-px mortar lines).
  - rgb = (row mod 7)+1, so it is never black.
  - When en=0, rgb=0.
- FSM states:
  - IDLE:
    - If init: clear the bitmap, set remaining=0, go to LOAD with row counter k=0. init has priority over a pending hit_req.
    - Else if hit_req and hit_ack was low last cycle: do the lookup and assert hit_ack for 1 cycle with hit_hit = inside & bit. If hit_hit=1, clear that bit and decrement remaining on the same edge.
  - LOAD:
    - Each cycle, set all COLS bits of row k and add COLS to remaining; k++.
    - After row ROWS-1, return to IDLE.
    - busy=1 throughout LOAD. Duration is ROWS cycles.
    - init during LOAD restarts the sweep: bitmap cleared, k=0, remaining=0.
    - hit_req is stalled (no ack) until IDLE.
- Handshake: at most one ack per request. The requester must drop hit_req the cycle after hit_ack; a request still high 2 cycles after its ack counts as a new request.
- remaining saturates at 0 and never underflows. An outside-field or already-empty hit gives hit_hit=0 and no change.
- Rendering continues during LOAD and reflects the partially loaded wall.

Optional Feature:
- Macro: BLOCK_FIELD_HIT_FLASH_EN.
- Defined:
  - A successful hit latches the brick's row/col and loads a flash counter with FLASH_LEN.
  - While the counter is nonzero, that brick's pixels render en=1, rgb=3'b111 (gap rule still applies), even though its bit is cleared. Counter decrements each clock.
  - A new hit retargets the flash and reloads the counter.
  - init or reset clears the counter.
- Undefined: a cleared brick disappears immediately; no extra registers.

Test Plan:
- Reset release, px=ORG_X+1, py=ORG_Y+1, visible=1 -> next cycle oBlock=4'b1001; remaining=32; cleared=0.
- Mortar and outside pixels: px=ORG_X+64 (gap column) -> oBlock=0; px=ORG_X+8*64 -> oBlock=0; visible=0 anywhere -> oBlock=0.
- Hit (hit_x=ORG_X+70, hit_y=ORG_Y+20):
  - -> hit_ack 1 cycle after req with hit_hit=1; remaining=31; rendering of row1/col1 then shows en=0.
  - Repeat the same hit -> hit_hit=0; remaining stays 31.
- Clear all 32 bricks by sequential hits -> remaining=0, cleared=1; a further hit -> hit_hit=0, remaining stays 0.
- init with hit_req high in the same cycle:
  - -> busy=1 for 4 cycles, remaining steps 0,8,16,24,32, no ack during LOAD.
  - Ack arrives in the first IDLE cycle.
  - init pulsed mid-LOAD restarts at 0.
- Async reset asserted mid-LOAD and mid-handshake -> all outputs go to reset values immediately; bitmap full, remaining=32.
- With BLOCK_FIELD_HIT_FLASH_EN: hit a brick -> its pixels show 4'b1111 for FLASH_LEN clocks, then 0.
